// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg: shared state encodings and key constants for the alarm clock
package alarm_clock_pkg;
    localparam int KEY_W = 4;
    localparam logic [KEY_W-1:0] NOKEY_DEFAULT = 4'hA;
    localparam logic [2:0] SHOW_TIME        = 3'd0;
    localparam logic [2:0] KEY_STORED       = 3'd1;
    localparam logic [2:0] KEY_WAITED       = 3'd2;
    localparam logic [2:0] KEY_ENTRY        = 3'd3;
    localparam logic [2:0] SHOW_ALARM       = 3'd4;
    localparam logic [2:0] SET_ALARM_TIME   = 3'd5;
    localparam logic [2:0] SET_CURRENT_TIME = 3'd6;
endpackage

// File: rtl/alarm_controller_timeout_counter.sv
// timeout_counter: counts one_sec ticks during key entry and flags the expiring tick
module timeout_counter #(
    parameter int unsigned TIMEOUT_SECS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);
    logic [3:0] count;
    always_ff @(posedge clk)
        if (!reset || clear) count <= 4'd0;
        else if (tick) count <= count + 4'd1;
    assign expired = tick && count == 4'(TIMEOUT_SECS - 1);
endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: main FSM sequencing key entry, alarm/time loads and display selection
module alarm_controller
    import alarm_clock_pkg::*;
#(
    parameter int unsigned TIMEOUT_SECS = 10,
    parameter logic [KEY_W-1:0] NOKEY = NOKEY_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic one_sec,
    input  logic [KEY_W-1:0] key,
    input  logic alarm_button,
    input  logic time_button,
    output logic shift,
    output logic show_new_time,
    output logic show_a,
    output logic load_alt,
    output logic load_new_c,
    output logic reset_count
);
    logic [2:0] state, next_state;
    logic entering, expired, has_key;
    assign has_key = key != NOKEY;
    assign entering = state == KEY_WAITED || state == KEY_ENTRY;
    timeout_counter #(.TIMEOUT_SECS(TIMEOUT_SECS)) u_timeout (
        .clk(clk),
        .reset(reset),
        .clear(!entering),
        .tick(one_sec),
        .expired(expired)
    );
    always_comb begin
        next_state = SHOW_TIME;
        case (state)
            SHOW_TIME:  next_state = alarm_button ? SHOW_ALARM : has_key ? KEY_STORED : SHOW_TIME;
            KEY_STORED: next_state = KEY_WAITED;
            KEY_WAITED: next_state = expired ? SHOW_TIME : !has_key ? KEY_ENTRY : KEY_WAITED;
            KEY_ENTRY:  next_state = alarm_button ? SET_ALARM_TIME :
                                     time_button  ? SET_CURRENT_TIME :
                                     has_key      ? KEY_STORED :
                                     expired      ? SHOW_TIME : KEY_ENTRY;
            SHOW_ALARM: next_state = alarm_button ? SHOW_ALARM : SHOW_TIME;
            default:    next_state = SHOW_TIME;
        endcase
    end
    always_ff @(posedge clk)
        if (!reset) state <= SHOW_TIME;
        else state <= next_state;
    assign shift         = state == KEY_STORED;
    assign show_new_time = entering;
    assign show_a        = state == SHOW_ALARM;
    assign load_alt      = state == SET_ALARM_TIME;
    assign load_new_c    = state == SET_CURRENT_TIME;
    assign reset_count   = state == SET_CURRENT_TIME;
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed self-checking bench for alarm_controller
module tb_alarm_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic one_sec = 1'b0;
    logic [3:0] key = 4'hA;
    logic alarm_button = 1'b0;
    logic time_button = 1'b0;
    logic shift, show_new_time, show_a, load_alt, load_new_c, reset_count;
    logic [5:0] outs;
    int n_checks = 0;
    int n_fail = 0;

    localparam logic [5:0] O_NONE  = 6'b000000;
    localparam logic [5:0] O_SHIFT = 6'b100000;
    localparam logic [5:0] O_SNT   = 6'b010000;
    localparam logic [5:0] O_SA    = 6'b001000;
    localparam logic [5:0] O_LA    = 6'b000100;
    localparam logic [5:0] O_LC    = 6'b000011;

    alarm_controller dut (
        .clk(clk),
        .reset(reset),
        .one_sec(one_sec),
        .key(key),
        .alarm_button(alarm_button),
        .time_button(time_button),
        .shift(shift),
        .show_new_time(show_new_time),
        .show_a(show_a),
        .load_alt(load_alt),
        .load_new_c(load_new_c),
        .reset_count(reset_count)
    );

    assign outs = {shift, show_new_time, show_a, load_alt, load_new_c, reset_count};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sec();
        one_sec = 1'b1;
        tick();
        one_sec = 1'b0;
    endtask

    // Leaves the FSM in KEY_ENTRY with a freshly cleared timeout window.
    task automatic enter_digit(input logic [3:0] d);
        key = d;
        tick();
        check("digit_shift", outs, O_SHIFT);
        key = 4'hA;
        tick();
        check("digit_waited", outs, O_SNT);
        tick();
        check("digit_entry", outs, O_SNT);
    endtask

    initial begin
        // 1: reset and idle
        tick();
        tick();
        check("reset", outs, O_NONE);
        reset = 1'b1;
        sec();
        check("idle_sec", outs, O_NONE);
        tick();
        check("idle", outs, O_NONE);

        // 2: held key gives a single shift
        key = 4'd5;
        tick();
        check("held_shift", outs, O_SHIFT);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_waited", outs, O_SNT);
        end
        key = 4'hA;
        tick();
        check("release_entry", outs, O_SNT);
        tick();
        check("entry_stay", outs, O_SNT);

        // 3: four digits then time_button
        for (int i = 1; i <= 4; i++) enter_digit(4'(i));
        time_button = 1'b1;
        tick();
        check("load_time", outs, O_LC);
        time_button = 1'b0;
        tick();
        check("after_load_time", outs, O_NONE);

        // 4: both buttons -> alarm load wins
        enter_digit(4'd7);
        enter_digit(4'd8);
        alarm_button = 1'b1;
        time_button = 1'b1;
        tick();
        check("both_buttons", outs, O_LA);
        alarm_button = 1'b0;
        time_button = 1'b0;
        tick();
        check("after_load_alarm", outs, O_NONE);
        tick();
        check("no_late_load", outs, O_NONE);

        // 5a: timeout after exactly ten ticks
        enter_digit(4'd3);
        for (int i = 0; i < 9; i++) begin
            sec();
            check("to_count", outs, O_SNT);
        end
        sec();
        check("timeout", outs, O_NONE);
        tick();
        check("timeout_idle", outs, O_NONE);

        // 5b: key coincident with the expiring tick wins and restarts the window
        enter_digit(4'd3);
        for (int i = 0; i < 9; i++) sec();
        check("pre_restart", outs, O_SNT);
        key = 4'd6;
        sec();
        check("key_beats_timeout", outs, O_SHIFT);
        key = 4'hA;
        tick();
        tick();
        check("restart_entry", outs, O_SNT);
        for (int i = 0; i < 9; i++) sec();
        check("restart_9", outs, O_SNT);
        sec();
        check("restart_timeout", outs, O_NONE);

        // 5c: button coincident with the expiring tick wins
        enter_digit(4'd2);
        for (int i = 0; i < 9; i++) sec();
        time_button = 1'b1;
        sec();
        check("button_beats_timeout", outs, O_LC);
        time_button = 1'b0;
        tick();
        check("after_button_timeout", outs, O_NONE);

        // 6: show alarm while held, reset mid-display
        alarm_button = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("show_alarm", outs, O_SA);
        end
        alarm_button = 1'b0;
        tick();
        check("alarm_release", outs, O_NONE);
        alarm_button = 1'b1;
        tick();
        check("show_alarm2", outs, O_SA);
        reset = 1'b0;
        tick();
        check("reset_mid_alarm", outs, O_NONE);
        reset = 1'b1;
        alarm_button = 1'b0;
        tick();
        check("post_reset", outs, O_NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
